fetch_unit: RTL

Instruction fetch stage of the RISC32 core, directly upstream of decode/immediate generation. Holds the PC and issues word requests to instruction memory. Buffers returned instruction words with their PCs in a small in-order queue and hands them to decode over a valid/ready handshake. A redirect from execute (branch/jump/jalr) flushes all buffered and in-flight fetches and restarts at the new target.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, in-order {pc, data} queue to decode.
// Optional FETCH_BYPASS_EN: a kept response meeting an empty queue is presented to decode in the same cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;
  logic          unused_bits;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_bits     = ^redirect_pc[1:0];
  assign imem_req_addr   = fetch_pc_reg;

  always_comb begin
    imem_req_valid = rst_n && (({1'b0, count_reg} + {1'b0, outstanding_reg}) < DEPTH_W);
    req_fire       = imem_req_valid && imem_req_ready;
    // A response landing in a redirect cycle belongs to the old path.
    rsp_keep       = imem_rsp_valid && (drop_reg == '0) && !redirect_valid;
    fifo_empty     = (count_reg == '0);
`ifdef FETCH_BYPASS_EN
    bypass         = rsp_keep && fifo_empty;
`else
    bypass         = 1'b0;
`endif
    inst_valid     = !fifo_empty || bypass;
    inst_data      = 32'h0;
    inst_pc        = 32'h0;
    if (!fifo_empty) begin
      inst_data = data_mem[rd_ptr_reg];
      inst_pc   = pc_mem[rd_ptr_reg];
    end else if (bypass) begin
      inst_data = imem_rsp_data;
      inst_pc   = rsp_pc_reg;
    end
    pop              = !fifo_empty && inst_ready;
    push             = rsp_keep && !(bypass && inst_ready);
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    count_next       = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight, including a request accepted this edge, is stale.
        fetch_pc_reg <= redirect_target;
        rsp_pc_reg   <= redirect_target;
        drop_reg     <= outstanding_next;
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
      end else begin
        if (req_fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (rsp_keep) rsp_pc_reg <= rsp_pc_reg + 32'd4;
        if (imem_rsp_valid && (drop_reg != '0)) drop_reg <= drop_reg - CW'(1);
        count_reg <= count_next;
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      data_mem[wr_ptr_reg] <= imem_rsp_data;
    end
  end
endmodule
